// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and length decode for the instruction fetch unit
package fetch_pkg;

  localparam int ADDR_W = 16;

  // Instruction length is encoded in the top two bits of the first word.
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 14;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       inst;
    logic [15:0]       inst_1;
    logic [15:0]       inst_2;
    logic [1:0]        len;
  } fetch_bundle_t;

  // Length in words; never returns 0.
  function automatic logic [1:0] decode_len(input logic [15:0] word);
    case (word[LEN_MSB:LEN_LSB])
      2'b11:   decode_len = LEN_3;
      2'b10:   decode_len = LEN_2;
      default: decode_len = LEN_1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular FIFO of fetch bundles with flush and head exposed
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_bundle_t push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_bundle_t head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_bundle_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  // A push into a full FIFO is legal only when the head leaves the same edge.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CNT_ONE;
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch requester with length decode and bundle FIFO
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_inst,
  input  logic [15:0]       mem_inst_1,
  input  logic [15:0]       mem_inst_2,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [15:0]       out_inst,
  output logic [15:0]       out_inst_1,
  output logic [15:0]       out_inst_2,
  output logic [1:0]        out_len
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] OCC_ONE   = (CW + 1)'(1);
  localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        resp_len;
  logic [ADDR_W-1:0] resp_bytes;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic [CW:0]       occ_next;
  logic              issue;
  logic [CW-1:0]     fifo_count;
  fetch_bundle_t     push_bundle;
  fetch_bundle_t     head;
  logic              redirect_lsb_unused;

  // The target is forced halfword-aligned, so its low bit never matters.
  assign redirect_lsb_unused = redirect_addr[0];

  assign resp_len   = decode_len(mem_inst);
  assign resp_bytes = {{(ADDR_W - 3){1'b0}}, resp_len, 1'b0};

  // Redirect beats the sequential successor of the response now arriving.
  always_comb begin
    next_pc = pc_q;
    if (redirect_valid) begin
      next_pc = {redirect_addr[ADDR_W-1:1], 1'b0};
    end else if (inflight_q) begin
      next_pc = inflight_pc_q + resp_bytes;
    end
  end

  assign mem_addr  = next_pc;
  assign push      = inflight_q && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);

  // Occupancy after this edge decides whether the next response has a slot.
  always_comb begin
    occ_next = {1'b0, fifo_count};
    if (redirect_valid) begin
      occ_next = '0;
    end else begin
      if (push) occ_next = occ_next + OCC_ONE;
      if (pop)  occ_next = occ_next - OCC_ONE;
    end
  end

  assign issue         = fetch_en && (occ_next < OCC_LIMIT);
  assign inflight_d    = issue;
  assign inflight_pc_d = next_pc;
  assign pc_d          = next_pc;

  assign push_bundle = '{pc: inflight_pc_q, inst: mem_inst, inst_1: mem_inst_1,
                         inst_2: mem_inst_2, len: resp_len};

  // Request tracking; reset drops any response still on its way back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_bundle),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign out_pc     = head.pc;
  assign out_inst   = head.inst;
  assign out_inst_1 = head.inst_1;
  assign out_inst_2 = head.inst_2;
  assign out_len    = head.len;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a program-walk model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_inst, mem_inst_1, mem_inst_2;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        out_valid, out_ready;
  logic [15:0] out_pc, out_inst, out_inst_1, out_inst_2;
  logic [1:0]  out_len;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .mem_addr(mem_addr),
    .mem_inst(mem_inst), .mem_inst_1(mem_inst_1), .mem_inst_2(mem_inst_2),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
    .out_len(out_len)
  );

  // Registered instruction memory, halfword indexed, wrapping at 64 KiB.
  logic [15:0] mem [32768];
  logic [14:0] widx0, widx1, widx2;
  assign widx0 = mem_addr[15:1];
  assign widx1 = widx0 + 15'd1;
  assign widx2 = widx0 + 15'd2;
  always @(posedge clk) begin
    mem_inst   <= mem[widx0];
    mem_inst_1 <= mem[widx1];
    mem_inst_2 <= mem[widx2];
  end

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  logic [15:0] exp_pc;
  logic [15:0] cur_addr;
  logic [15:0] p_exp;
  int acc_before;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Program model: word k of the instruction at byte address a.
  function automatic logic [15:0] rd(input logic [15:0] a, input int k);
    logic [14:0] i;
    i = a[15:1] + 15'(k);
    return mem[i];
  endfunction

  function automatic int lenof(input logic [15:0] w);
    int top;
    top = int'(w) / 16384;
    if (top == 3) return 3;
    if (top == 2) return 2;
    return 1;
  endfunction

  function automatic logic [15:0] walk(input logic [15:0] a, input int n);
    logic [15:0] p;
    p = a;
    for (int i = 0; i < n; i++) p = p + 16'(2 * lenof(rd(p, 0)));
    return p;
  endfunction

  // One clock cycle: drive, score the handshake, cross the edge, check hold.
  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [15:0] ra);
    logic        hold;
    logic [18:0] s_pl;
    logic [47:0] s_in;
    fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_addr = ra;
    #1;
    cur_addr = mem_addr;
    hold = 1'b0;
    s_pl = '0;
    s_in = '0;
    if (rst_n) begin
      if (rv) begin
        exp_pc = ra & 16'hFFFE;
      end else if (out_valid && rdy) begin
        check("bundle_pc", out_pc, exp_pc);
        check("bundle_inst", out_inst, rd(exp_pc, 0));
        check("bundle_inst_1", out_inst_1, rd(exp_pc, 1));
        check("bundle_inst_2", out_inst_2, rd(exp_pc, 2));
        check("bundle_len", out_len, lenof(rd(exp_pc, 0)));
        exp_pc = walk(exp_pc, 1);
        accepted++;
      end else if (out_valid) begin
        hold = 1'b1;
        s_pl = {out_valid, out_pc, out_len};
        s_in = {out_inst, out_inst_1, out_inst_2};
      end
    end
    @(posedge clk);
    #1;
    if (hold && rst_n) begin
      check("hold_pc_len", {out_valid, out_pc, out_len}, s_pl);
      check("hold_inst", {out_inst, out_inst_1, out_inst_2}, s_in);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001; mem[1] = 16'h8002; mem[2] = 16'h0BEE; mem[3] = 16'hC003;
    mem[4] = 16'h1111; mem[5] = 16'h2222; mem[6] = 16'h0004;
    mem[15'h7FFF] = 16'h8000;

    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;
    exp_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_addr", mem_addr, 16'h0000);
    check("reset_pc", out_pc, 16'h0000);
    check("reset_len", out_len, 2'd0);
    check("reset_inst", {out_inst, out_inst_1, out_inst_2}, 48'h0);

    // Sequential fetch from byte 0.
    rst_n = 1'b1;
    step(1, 1, 0, 0); check("seq_addr0", cur_addr, 16'h0000); check("latency_e1", out_valid, 1'b0);
    step(1, 1, 0, 0); check("seq_addr1", cur_addr, 16'h0002); check("latency_e2", out_valid, 1'b1);
    check("seq_first_pc", out_pc, 16'h0000);
    step(1, 1, 0, 0); check("seq_addr2", cur_addr, 16'h0006);
    check("seq_b2_pc", out_pc, 16'h0002); check("seq_b2_len", out_len, 2'd2);
    check("seq_b2_inst_1", out_inst_1, 16'h0BEE);
    step(1, 1, 0, 0); check("seq_addr3", cur_addr, 16'h000C);
    check("seq_b3_pc", out_pc, 16'h0006); check("seq_b3_len", out_len, 2'd3);
    check("seq_b3_tail", {out_inst_1, out_inst_2}, 32'h1111_2222);
    step(1, 1, 0, 0);
    check("seq_b4_pc", out_pc, 16'h000C); check("seq_b4_len", out_len, 2'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0); check("stream_valid", out_valid, 1'b1);
    end

    // Backpressure: FIFO fills, fetch stalls at the address after the two held bundles.
    step(1, 0, 0, 0);
    p_exp = walk(exp_pc, 2);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      check("bp_addr_held", cur_addr, p_exp);
      check("bp_valid", out_valid, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0); check("bp_release_valid", out_valid, 1'b1);
    end

    // Redirect with a bundle queued and a request outstanding.
    step(1, 0, 1, 16'h0041);
    check("redir_addr", cur_addr, 16'h0040);
    check("redir_flush", out_valid, 1'b0);
    step(1, 1, 0, 0);
    check("redir_first_valid", out_valid, 1'b1);
    check("redir_first_pc", out_pc, 16'h0040);
    repeat (4) step(1, 1, 0, 0);

    // Address wrap at the top of memory.
    step(1, 1, 1, 16'hFFFE);
    check("wrap_redir_addr", cur_addr, 16'hFFFE);
    step(1, 1, 0, 0);
    check("wrap_next_addr", cur_addr, 16'h0002);
    check("wrap_pc", out_pc, 16'hFFFE);
    check("wrap_len", out_len, 2'd2);
    repeat (4) step(1, 1, 0, 0);

    // fetch_en low for three cycles.
    p_exp = walk(exp_pc, 2);
    step(0, 1, 0, 0);
    check("fe_addr_x0", cur_addr, p_exp);
    check("fe_inflight_pushed", out_valid, 1'b1);
    step(0, 1, 0, 0); check("fe_addr_x1", cur_addr, p_exp);
    step(0, 1, 0, 0); check("fe_addr_x2", cur_addr, p_exp);
    check("fe_drained", out_valid, 1'b0);
    step(1, 1, 0, 0); check("fe_resume_addr", cur_addr, p_exp);
    step(1, 1, 0, 0); check("fe_resume_pc", out_pc, p_exp);
    repeat (4) step(1, 1, 0, 0);

    // Asynchronous reset with two bundles held.
    repeat (3) step(1, 0, 0, 0);
    check("ar_full_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_addr", mem_addr, 16'h0000);
    check("ar_pc", out_pc, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 16'h0000;
    step(1, 1, 0, 0); check("ar_restart_addr", cur_addr, 16'h0000); check("ar_latency_e1", out_valid, 1'b0);
    step(1, 1, 0, 0); check("ar_latency_e2", out_valid, 1'b1); check("ar_first_pc", out_pc, 16'h0000);

    // Randomized traffic against the program-walk model.
    acc_before = accepted;
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           16'($urandom));
    end
    check("random_progress", (accepted - acc_before) > 150, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
